// File: rtl/out_disp_pkg.sv
// Shared types and segment tables for the out_display_driver slice.
// Double-dabble nibble adjust helper lives here too.
package out_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [3:0] dd_nib(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [11:0] dd_adjust(
    input logic [11:0] b
  );
    return {dd_nib(b[11:8]),
            dd_nib(b[7:4]),
            dd_nib(b[3:0])};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to seven-segment decoder.
// Minus overrides blank; codes above 9 decode to blank.
module seg7_decode
  import out_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (minus_i) begin
      seg_o = SEG_MINUS;
    end else if (!blank_i && code_i <= 4'd9) begin
      seg_o = SEG_DIGIT[code_i];
    end
  end

endmodule

// File: rtl/out_display_driver.sv
// 4-digit multiplexed 7-seg driver with double-dabble BCD.
// OUT_DISP_SIGNED_EN selects two's complement input with minus sign.
module out_display_driver
  import out_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] value,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [15:0] PRE_MAX =
    16'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [19:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  pval_q, pval_d;
  logic [3:0]  d0_q, d0_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d2_q, d2_d;
  logic [15:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]  seg_q;
  logic [3:0]  an_q;

  logic        start;
  logic [7:0]  src;
  logic [7:0]  mag;
  logic [19:0] adj;
  logic [3:0]  code;
  logic        blank;
  logic        minus;
  logic [6:0]  seg_w;

`ifdef OUT_DISP_SIGNED_EN
  logic sneg_q, sneg_d;
  logic neg_q, neg_d;
  assign mag = src[7] ? 8'(-src) : src;
`else
  assign mag = src;
`endif

  assign adj = {dd_adjust(sh_q[19:8]),
                sh_q[7:0]};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    start   = 1'b0;
    src     = value;
`ifdef OUT_DISP_SIGNED_EN
    sneg_d  = sneg_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) start = 1'b1;
      end
      CONV: begin
        sh_d  = {adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
        if (load) begin
          pend_d = 1'b1;
          pval_d = value;
        end
      end
      DONE: begin
        d0_d = sh_q[11:8];
        d1_d = sh_q[15:12];
        d2_d = sh_q[19:16];
`ifdef OUT_DISP_SIGNED_EN
        neg_d = sneg_q;
`endif
        if (pend_q) begin
          // pending wins; a same-cycle load re-arms it
          start  = 1'b1;
          src    = pval_q;
          pend_d = load;
          if (load) pval_d = value;
        end else if (load) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = CONV;
      cnt_d   = 3'd0;
      sh_d    = {12'd0, mag};
`ifdef OUT_DISP_SIGNED_EN
      sneg_d  = src[7];
`endif
    end
  end

  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? 16'd0
                               : pre_q + 16'd1;
    idx_d = (pre_q == PRE_MAX) ? idx_q + 1'b1
                               : idx_q;
  end

  always_comb begin
    code  = 4'd0;
    blank = 1'b0;
    minus = 1'b0;
    unique case (idx_q)
      2'd0: code = d0_q;
      2'd1: begin
        code  = d1_q;
        blank = (BLANK_LZ != 0) &&
                d2_q == 4'd0 && d1_q == 4'd0;
      end
      2'd2: begin
        code  = d2_q;
        blank = (BLANK_LZ != 0) && d2_q == 4'd0;
      end
      default: begin
`ifdef OUT_DISP_SIGNED_EN
        minus = neg_q;
        blank = !neg_q;
`else
        blank = 1'b1;
`endif
      end
    endcase
  end

  seg7_decode u_dec (
    .code_i  (code),
    .blank_i (blank),
    .minus_i (minus),
    .seg_o   (seg_w)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '0;
`ifdef OUT_DISP_SIGNED_EN
      sneg_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_w;
      an_q    <= 4'(1) << idx_q;
`ifdef OUT_DISP_SIGNED_EN
      sneg_q  <= sneg_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_out_display_driver.sv
// Directed self-checking bench for out_display_driver.
// Two instances: BLANK_LZ=1 (a) and BLANK_LZ=0 (b).
module tb_out_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] value;
  logic       load;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  logic [6:0] fa [4];
  logic [6:0] fb [4];
  logic [6:0] ea [4];
  logic [6:0] eb [4];

  always #5 clk = ~clk;

  out_display_driver #(
    .SCAN_DIV (SD),
    .BLANK_LZ (1)
  ) dut_a (
    .clk   (clk),
    .clr   (clr),
    .value (value),
    .load  (load),
    .seg   (seg_a),
    .an    (an_a),
    .busy  (busy_a)
  );

  out_display_driver #(
    .SCAN_DIV (SD),
    .BLANK_LZ (0)
  ) dut_b (
    .clk   (clk),
    .clr   (clr),
    .value (value),
    .load  (load),
    .seg   (seg_b),
    .an    (an_b),
    .busy  (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) begin
      fa[i] = 'x;
      fb[i] = 'x;
    end
    repeat (4 * SD) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (an_a[i]) fa[i] = seg_a;
        if (an_b[i]) fb[i] = seg_b;
      end
    end
  endtask

  task automatic start_conv(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (9) tick();
  endtask

  task automatic test_reset();
    logic [3:0] ean;
    logic [6:0] es;
    clr   = 1'b1;
    load  = 1'b0;
    value = 8'h00;
    repeat (3) tick();
    checks++;
    if (seg_a !== 7'h00 || an_a !== 4'h0 ||
        busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset: seg=%h an=%b busy=%b",
               seg_a, an_a, busy_a,
               " want 00 0000 0");
    end
    clr = 1'b0;
    for (int k = 0; k < 4 * SD; k++) begin
      tick();
      ean = 4'(1) << ((k / SD) % 4);
      es  = (ean == 4'b0001) ? 7'h3F : 7'h00;
      checks++;
      if (an_a !== ean || seg_a !== es) begin
        errors++;
        $display("FAIL scan k=%0d: an=%b seg=%h",
                 k, an_a, seg_a,
                 " want %b %h", ean, es);
      end
      es = (ean == 4'b1000) ? 7'h00 : 7'h3F;
      checks++;
      if (an_b !== ean || seg_b !== es) begin
        errors++;
        $display("FAIL scan_nolz k=%0d: an=%b seg=%h",
                 k, an_b, seg_b,
                 " want %b %h", ean, es);
      end
    end
  endtask

  task automatic test_load_255();
    value = 8'hFF;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick();
      checks++;
      if (busy_a !== (c <= 8)) begin
        errors++;
        $display("FAIL busy255 c=%0d: got %b want %b",
                 c, busy_a, (c <= 8));
      end
    end
    capture();
`ifdef OUT_DISP_SIGNED_EN
    ea = '{7'h06, 7'h00, 7'h00, 7'h40};
`else
    ea = '{7'h6D, 7'h6D, 7'h5B, 7'h00};
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fa[i] !== ea[i]) begin
        errors++;
        $display("FAIL frame255[%0d]: got %h want %h",
                 i, fa[i], ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e7 [4];
    logic [6:0] es;
    e7 = '{7'h07, 7'h00, 7'h00, 7'h00};
    value = 8'd7;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) begin
        if (c == 3) begin
          value = 8'd100;
          load  = 1'b1;
        end
        tick();
        load = 1'b0;
      end
      checks++;
      if (busy_a !== (c <= 17)) begin
        errors++;
        $display("FAIL b2b_busy c=%0d: got %b want %b",
                 c, busy_a, (c <= 17));
      end
      if (c >= 10) begin
        es = 7'h7F;
        for (int i = 0; i < 4; i++)
          if (an_a[i]) es = e7[i];
        checks++;
        if (seg_a !== es) begin
          errors++;
          $display("FAIL b2b_seven c=%0d: got %h want %h",
                   c, seg_a, es);
        end
      end
    end
    capture();
    ea = '{7'h3F, 7'h3F, 7'h06, 7'h00};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fa[i] !== ea[i]) begin
        errors++;
        $display("FAIL frame100[%0d]: got %h want %h",
                 i, fa[i], ea[i]);
      end
    end
  endtask

  task automatic test_blank();
    start_conv(8'd5);
    capture();
    ea = '{7'h6D, 7'h00, 7'h00, 7'h00};
    eb = '{7'h6D, 7'h3F, 7'h3F, 7'h00};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fa[i] !== ea[i]) begin
        errors++;
        $display("FAIL blank_lz[%0d]: got %h want %h",
                 i, fa[i], ea[i]);
      end
      checks++;
      if (fb[i] !== eb[i]) begin
        errors++;
        $display("FAIL no_blank[%0d]: got %h want %h",
                 i, fb[i], eb[i]);
      end
    end
  endtask

  task automatic test_clr_abort();
    logic [6:0] ez [4];
    logic [6:0] es;
    ez = '{7'h3F, 7'h00, 7'h00, 7'h00};
    value = 8'd200;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0 || an_a !== 4'h0 ||
        seg_a !== 7'h00) begin
      errors++;
      $display("FAIL clr_abort: busy=%b an=%b seg=%h",
               busy_a, an_a, seg_a,
               " want 0 0000 00");
    end
    clr = 1'b0;
    for (int c = 5; c <= 13; c++) begin
      tick();
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL clr_busy c=%0d: got %b want 0",
                 c, busy_a);
      end
      if (c == 5) begin
        checks++;
        if (an_a !== 4'b0001) begin
          errors++;
          $display("FAIL clr_an: got %b want 0001",
                   an_a);
        end
      end
      es = 7'h7F;
      for (int i = 0; i < 4; i++)
        if (an_a[i]) es = ez[i];
      checks++;
      if (seg_a !== es) begin
        errors++;
        $display("FAIL clr_seg c=%0d: got %h want %h",
                 c, seg_a, es);
      end
    end
  endtask

  task automatic test_values();
    logic [7:0] vals [3];
    logic [6:0] exp [3][4];
`ifdef OUT_DISP_SIGNED_EN
    vals = '{8'h80, 8'hFF, 8'h7F};
    exp[0] = '{7'h7F, 7'h5B, 7'h06, 7'h40};
    exp[1] = '{7'h06, 7'h00, 7'h00, 7'h40};
    exp[2] = '{7'h07, 7'h5B, 7'h06, 7'h00};
`else
    vals = '{8'h80, 8'h0A, 8'h63};
    exp[0] = '{7'h7F, 7'h5B, 7'h06, 7'h00};
    exp[1] = '{7'h3F, 7'h06, 7'h00, 7'h00};
    exp[2] = '{7'h6F, 7'h6F, 7'h00, 7'h00};
`endif
    for (int v = 0; v < 3; v++) begin
      start_conv(vals[v]);
      capture();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fa[i] !== exp[v][i]) begin
          errors++;
          $display("FAIL val %h [%0d]: got %h want %h",
                   vals[v], i, fa[i], exp[v][i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_255();
    test_back_to_back();
    test_blank();
    test_clr_abort();
    test_values();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
